// File: rtl/ascon_pkg.sv
// ascon_pkg: shared types and constants for the ASCON-128 control sequencer.
//   - state_e      : controller state encoding
//   - ctrl_out_t   : registered strobe/status bundle driven by the controller
//   - ROUND_*      : permutation round bounds (pa = 0..11, pb = 6..11)
package ascon_pkg;

  localparam int unsigned ROUND_W = 4;
  localparam int unsigned BLOCK_W = 3;

  localparam logic [ROUND_W-1:0] ROUND_A_START = 4'd0;
  localparam logic [ROUND_W-1:0] ROUND_B_START = 4'd6;
  localparam logic [ROUND_W-1:0] ROUND_LAST    = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_AD = 3'd2,
    ST_AD      = 3'd3,
    ST_WAIT_PT = 3'd4,
    ST_PT      = 3'd5,
    ST_FINAL   = 3'd6,
    ST_TAG     = 3'd7
  } state_e;

  typedef struct packed {
    logic busy;
    logic data_ready;
    logic perm_ena;
    logic perm_init;
    logic xor_key_begin;
    logic xor_key_end;
    logic xor_data_begin;
    logic xor_lsb_end;
    logic cipher_valid;
    logic tag_valid;
    logic ena_block;
    logic init_block;
  } ctrl_out_t;

endpackage

// File: rtl/ascon_ctrl_fsm_if.sv
// ascon_ctrl_fsm_if: data handshake and block-counter link of the sequencer.
//   data_valid  : input block available          (source -> controller)
//   data_ready  : controller accepts a block     (controller -> source)
//   block_idx   : current block index            (counter -> controller)
//   ena_block   : block counter enable           (controller -> counter)
//   init_block  : block counter clear            (controller -> counter)
// Modports: master = data source / block counter side, slave = controller.
interface ascon_ctrl_fsm_if;
  import ascon_pkg::*;

  logic               data_valid;
  logic               data_ready;
  logic [BLOCK_W-1:0] block_idx;
  logic               ena_block;
  logic               init_block;

  modport master (
    output data_valid,
    output block_idx,
    input  data_ready,
    input  ena_block,
    input  init_block
  );

  modport slave (
    input  data_valid,
    input  block_idx,
    output data_ready,
    output ena_block,
    output init_block
  );

endinterface

// File: rtl/counter_round.sv
// counter_round: permutation round counter with load and increment.
//   clock_i, resetb_i : clock, async active-low reset (clears to 0)
//   ena_i             : increment by one
//   load_i            : load load_val_i (takes priority over ena_i)
//   round_o           : registered round index
//   round_nxt_c       : value round_o takes at the next edge
module counter_round
  import ascon_pkg::*;
(
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               ena_i,
  input  logic               load_i,
  input  logic [ROUND_W-1:0] load_val_i,
  output logic [ROUND_W-1:0] round_o,
  output logic [ROUND_W-1:0] round_nxt_c
);

  logic [ROUND_W-1:0] round_q;
  logic [ROUND_W-1:0] round_d;

  // Next value; holds when neither load nor enable is set.
  always_comb begin
    round_d = round_q;
    if (load_i) begin
      round_d = load_val_i;
    end else if (ena_i) begin
      round_d = round_q + ROUND_W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

  assign round_o     = round_q;
  assign round_nxt_c = round_d;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm: ASCON-128 encryption sequencer (init, AD, PT, finalisation).
//   clock_i, resetb_i  : clock, async active-low reset
//   start_i            : start a new message (ignored while busy)
//   bus_if (slave)     : data_valid/data_ready handshake and block counter
//                        link (block_idx in, ena_block/init_block out)
//   round_o            : permutation round index
//   perm_ena_o         : permutation executes a round this cycle
//   perm_init_o        : state loads IV||K||N
//   xor_key_begin_o    : XOR 0||K||0 before the round
//   xor_key_end_o      : XOR 0*||K after the round
//   xor_data_begin_o   : XOR data block into the rate before the round
//   xor_lsb_end_o      : domain-separation LSB XOR after the round
//   cipher_valid_o     : ciphertext block valid
//   tag_valid_o        : one-cycle tag/completion pulse
//   busy_o             : controller not idle
// All outputs are registered; they are decoded from the next state and
// next round so they line up with the state/round they describe.
module ascon_ctrl_fsm
  import ascon_pkg::*;
#(
  parameter int unsigned NB_AD_BLOCKS = 1,
  parameter int unsigned NB_PT_BLOCKS = 4
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               start_i,
  ascon_ctrl_fsm_if.slave    bus_if,
  output logic [ROUND_W-1:0] round_o,
  output logic               perm_ena_o,
  output logic               perm_init_o,
  output logic               xor_key_begin_o,
  output logic               xor_key_end_o,
  output logic               xor_data_begin_o,
  output logic               xor_lsb_end_o,
  output logic               cipher_valid_o,
  output logic               tag_valid_o,
  output logic               busy_o
);

  localparam logic HAS_AD = (NB_AD_BLOCKS != 0);
  localparam logic [BLOCK_W-1:0] LAST_AD_IDX =
    BLOCK_W'((NB_AD_BLOCKS == 0) ? 0 : NB_AD_BLOCKS - 1);
  localparam logic [BLOCK_W-1:0] LAST_PT_IDX =
    BLOCK_W'((NB_PT_BLOCKS == 0) ? 0 : NB_PT_BLOCKS - 1);

  state_e             state_q;
  state_e             state_d;
  ctrl_out_t          out_q;
  ctrl_out_t          out_d;
  logic               rnd_ena;
  logic               rnd_load;
  logic [ROUND_W-1:0] rnd_load_val;
  logic [ROUND_W-1:0] round_q;
  logic [ROUND_W-1:0] round_d;
  logic               round_last;
  logic               ad_last;
  logic               pt_last;

  assign round_last = (round_q == ROUND_LAST);
  // Block index is stable for a whole block; it only moves after ena_block.
  assign ad_last    = (bus_if.block_idx == LAST_AD_IDX);
  assign pt_last    = (bus_if.block_idx == LAST_PT_IDX);

  counter_round u_counter_round (
    .clock_i     (clock_i),
    .resetb_i    (resetb_i),
    .ena_i       (rnd_ena),
    .load_i      (rnd_load),
    .load_val_i  (rnd_load_val),
    .round_o     (round_q),
    .round_nxt_c (round_d)
  );

  // Next-state and round-counter control.
  always_comb begin
    state_d      = state_q;
    rnd_ena      = 1'b0;
    rnd_load     = 1'b0;
    rnd_load_val = ROUND_A_START;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_INIT;
          rnd_load = 1'b1;
        end
      end
      ST_INIT: begin
        if (round_last) begin
          state_d = HAS_AD ? ST_WAIT_AD : ST_WAIT_PT;
        end else begin
          rnd_ena = 1'b1;
        end
      end
      ST_WAIT_AD: begin
        if (bus_if.data_valid) begin
          state_d      = ST_AD;
          rnd_load     = 1'b1;
          rnd_load_val = ROUND_B_START;
        end
      end
      ST_AD: begin
        if (round_last) begin
          state_d = ad_last ? ST_WAIT_PT : ST_WAIT_AD;
        end else begin
          rnd_ena = 1'b1;
        end
      end
      ST_WAIT_PT: begin
        if (bus_if.data_valid) begin
          rnd_load = 1'b1;
          if (pt_last) begin
            state_d = ST_FINAL;
          end else begin
            state_d      = ST_PT;
            rnd_load_val = ROUND_B_START;
          end
        end
      end
      ST_PT: begin
        if (round_last) begin
          state_d = ST_WAIT_PT;
        end else begin
          rnd_ena = 1'b1;
        end
      end
      ST_FINAL: begin
        if (round_last) begin
          state_d = ST_TAG;
        end else begin
          rnd_ena = 1'b1;
        end
      end
      ST_TAG: begin
        state_d  = ST_IDLE;
        rnd_load = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        rnd_load = 1'b1;
      end
    endcase
  end

  // Output decode for the upcoming (state, round) pair.
  always_comb begin
    out_d            = '0;
    out_d.busy       = (state_d != ST_IDLE);
    out_d.data_ready = (state_d == ST_WAIT_AD) || (state_d == ST_WAIT_PT);
    out_d.perm_ena   = (state_d == ST_INIT) || (state_d == ST_AD) ||
                       (state_d == ST_PT)   || (state_d == ST_FINAL);
    case (state_d)
      ST_INIT: begin
        out_d.perm_init = (round_d == ROUND_A_START);
        if (round_d == ROUND_LAST) begin
          out_d.xor_key_end = 1'b1;
          out_d.ena_block   = 1'b1;
          out_d.init_block  = 1'b1;
          out_d.xor_lsb_end = !HAS_AD;
        end
      end
      ST_AD: begin
        out_d.xor_data_begin = (round_d == ROUND_B_START);
        if (round_d == ROUND_LAST) begin
          out_d.ena_block   = 1'b1;
          out_d.init_block  = ad_last;
          out_d.xor_lsb_end = ad_last;
        end
      end
      ST_PT: begin
        out_d.xor_data_begin = (round_d == ROUND_B_START);
        out_d.cipher_valid   = (round_d == ROUND_B_START);
        out_d.ena_block      = (round_d == ROUND_LAST);
      end
      ST_FINAL: begin
        out_d.xor_data_begin = (round_d == ROUND_A_START);
        out_d.xor_key_begin  = (round_d == ROUND_A_START);
        out_d.cipher_valid   = (round_d == ROUND_A_START);
        out_d.xor_key_end    = (round_d == ROUND_LAST);
      end
      ST_TAG: begin
        out_d.tag_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign round_o           = round_q;
  assign perm_ena_o        = out_q.perm_ena;
  assign perm_init_o       = out_q.perm_init;
  assign xor_key_begin_o   = out_q.xor_key_begin;
  assign xor_key_end_o     = out_q.xor_key_end;
  assign xor_data_begin_o  = out_q.xor_data_begin;
  assign xor_lsb_end_o     = out_q.xor_lsb_end;
  assign cipher_valid_o    = out_q.cipher_valid;
  assign tag_valid_o       = out_q.tag_valid;
  assign busy_o            = out_q.busy;
  assign bus_if.data_ready = out_q.data_ready;
  assign bus_if.ena_block  = out_q.ena_block;
  assign bus_if.init_block = out_q.init_block;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb_ascon_ctrl_fsm: directed bench for ascon_ctrl_fsm with a behavioural
// 3-bit block counter. DUT "a" uses default parameters, DUT "z" has no AD.
// Cycle n is the interval after the n-th rising edge following start_i.
// Compared vector: {busy, ready, perm_ena, perm_init, key_begin, key_end,
//                   data_begin, lsb_end, cipher_valid, tag_valid,
//                   ena_block, init_block, round[3:0]}
module tb_ascon_ctrl_fsm;
  import ascon_pkg::*;

  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic resetb;
  logic start_a, start_z;
  logic valid_a, valid_z;
  logic [2:0] blk_a, blk_z;

  logic [3:0] round_a, round_z;
  logic pe_a, pi_a, kb_a, ke_a, db_a, lsb_a, cv_a, tv_a, busy_a;
  logic pe_z, pi_z, kb_z, ke_z, db_z, lsb_z, cv_z, tv_z, busy_z;

  int n_checks = 0;
  int n_fail   = 0;

  ascon_ctrl_fsm_if bus_a ();
  ascon_ctrl_fsm_if bus_z ();

  assign bus_a.data_valid = valid_a;
  assign bus_a.block_idx  = blk_a;
  assign bus_z.data_valid = valid_z;
  assign bus_z.block_idx  = blk_z;

  ascon_ctrl_fsm u_dut_a (
    .clock_i          (clock_i),
    .resetb_i         (resetb),
    .start_i          (start_a),
    .bus_if           (bus_a),
    .round_o          (round_a),
    .perm_ena_o       (pe_a),
    .perm_init_o      (pi_a),
    .xor_key_begin_o  (kb_a),
    .xor_key_end_o    (ke_a),
    .xor_data_begin_o (db_a),
    .xor_lsb_end_o    (lsb_a),
    .cipher_valid_o   (cv_a),
    .tag_valid_o      (tv_a),
    .busy_o           (busy_a)
  );

  ascon_ctrl_fsm #(.NB_AD_BLOCKS(0), .NB_PT_BLOCKS(4)) u_dut_z (
    .clock_i          (clock_i),
    .resetb_i         (resetb),
    .start_i          (start_z),
    .bus_if           (bus_z),
    .round_o          (round_z),
    .perm_ena_o       (pe_z),
    .perm_init_o      (pi_z),
    .xor_key_begin_o  (kb_z),
    .xor_key_end_o    (ke_z),
    .xor_data_begin_o (db_z),
    .xor_lsb_end_o    (lsb_z),
    .cipher_valid_o   (cv_z),
    .tag_valid_o      (tv_z),
    .busy_o           (busy_z)
  );

  // External block counters.
  always_ff @(posedge clock_i or negedge resetb) begin
    if (!resetb) begin
      blk_a <= 3'd0;
      blk_z <= 3'd0;
    end else begin
      if (bus_a.ena_block) blk_a <= bus_a.init_block ? 3'd0 : blk_a + 3'd1;
      if (bus_z.ena_block) blk_z <= bus_z.init_block ? 3'd0 : blk_z + 3'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [15:0] got_a();
    return {busy_a, bus_a.data_ready, pe_a, pi_a, kb_a, ke_a, db_a, lsb_a,
            cv_a, tv_a, bus_a.ena_block, bus_a.init_block, round_a};
  endfunction

  function automatic logic [15:0] got_z();
    return {busy_z, bus_z.data_ready, pe_z, pi_z, kb_z, ke_z, db_z, lsb_z,
            cv_z, tv_z, bus_z.ena_block, bus_z.init_block, round_z};
  endfunction

  // Hand-derived timeline for NB_AD=1, NB_PT=4, no stalls:
  // INIT 1..12, WAIT_AD 13, AD 14..19, WAIT_PT 20/27/34/41,
  // PT 21..26/28..33/35..40, FINAL 42..53, TAG 54, idle from 55.
  function automatic logic [15:0] exp_vec(input int c);
    logic busy, rdy, pe, pi, kb, ke, db, lsb, cv, tv, eb, ib;
    int r;
    busy = (c >= 1) && (c <= 54);
    rdy  = c inside {13, 20, 27, 34, 41};
    pe   = busy && !rdy && (c != 54);
    pi   = (c == 1);
    kb   = (c == 42);
    ke   = (c == 12) || (c == 53);
    db   = c inside {14, 21, 28, 35, 42};
    lsb  = (c == 19);
    cv   = c inside {21, 28, 35, 42};
    tv   = (c == 54);
    eb   = c inside {12, 19, 26, 33, 40};
    ib   = c inside {12, 19};
    if (!busy)                r = 0;
    else if (c <= 12)         r = c - 1;
    else if (rdy || c == 54)  r = 11;
    else if (c <= 19)         r = c - 8;
    else if (c <= 26)         r = c - 15;
    else if (c <= 33)         r = c - 22;
    else if (c <= 40)         r = c - 29;
    else                      r = c - 42;
    return {busy, rdy, pe, pi, kb, ke, db, lsb, cv, tv, eb, ib, 4'(r)};
  endfunction

  // Block index expected while waiting for a PT block.
  function automatic int exp_blk(input int m);
    if (m < 27)      return 0;
    else if (m < 34) return 1;
    else if (m < 41) return 2;
    else             return 3;
  endfunction

  // A stall in the first WAIT_PT (cycle 20) freezes the timeline there.
  function automatic int map_cyc(input int c, input int stall);
    if (stall == 0 || c <= 20) return c;
    else if (c <= 20 + stall)  return 20;
    else                       return c - stall;
  endfunction

  // One message on DUT a; the current cycle is cycle 0.
  task automatic run_msg(input string tag, input int stall, input bit sparse, input int ncyc);
    logic [15:0] e;
    int m;
    start_a = 1'b1;
    valid_a = !sparse;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      start_a = 1'b0;
      m = map_cyc(c, stall);
      e = exp_vec(m);
      check_eq($sformatf("%s_c%0d", tag, c), got_a(), e);
      if (e[14] && m >= 20)
        check_eq($sformatf("%s_blk_c%0d", tag, c), 16'(blk_a), 16'(exp_blk(m)));
      if (sparse) begin
        // valid only in wait states plus stray pulses in PT; stray starts
        valid_a = e[14] || (c == 22) || (c == 23);
        start_a = (c == 15) || (c == 30);
      end else begin
        valid_a = !((stall > 0) && (c >= 20) && (c < 20 + stall));
      end
    end
  endtask

  initial begin
    int lsb_cnt;
    int rdy_cnt;
    resetb  = 1'b0;
    start_a = 1'b0;
    start_z = 1'b0;
    valid_a = 1'b0;
    valid_z = 1'b0;
    #12;
    check_eq("rst_a", got_a(), 16'h0000);
    check_eq("rst_z", got_z(), 16'h0000);
    @(negedge clock_i);
    resetb = 1'b1;
    tick();

    run_msg("s1", 0, 1'b0, 55);
    run_msg("stall", 5, 1'b0, 60);
    run_msg("noise", 0, 1'b1, 55);

    // Reset during FINAL round 4 (cycle 46).
    run_msg("s4", 0, 1'b0, 46);
    resetb = 1'b0;
    #1;
    check_eq("s4_rst_out", got_a(), 16'h0000);
    check_eq("s4_rst_blk", 16'(blk_a), 16'h0000);
    @(negedge clock_i);
    resetb = 1'b1;
    tick();
    run_msg("s4b", 0, 1'b0, 55);

    // No-AD configuration.
    lsb_cnt = 0;
    rdy_cnt = 0;
    start_z = 1'b1;
    valid_z = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      tick();
      start_z = 1'b0;
      lsb_cnt += int'(lsb_z);
      rdy_cnt += int'(bus_z.data_ready);
      case (c)
        12: check_eq("z_c12", got_z(), 16'b1010_0101_0011_1011);
        13: check_eq("z_c13", got_z(), 16'b1100_0000_0000_1011);
        14: check_eq("z_c14", got_z(), 16'b1010_0010_1000_0110);
        19: check_eq("z_c19", got_z(), 16'b1010_0000_0010_1011);
        34: begin
          check_eq("z_c34", got_z(), 16'b1100_0000_0000_1011);
          check_eq("z_blk_c34", 16'(blk_z), 16'd3);
        end
        35: check_eq("z_c35", got_z(), 16'b1010_1010_1000_0000);
        46: check_eq("z_c46", got_z(), 16'b1010_0100_0000_1011);
        47: check_eq("z_c47", got_z(), 16'b1000_0000_0100_1011);
        48: check_eq("z_c48", got_z(), 16'h0000);
        default: ;
      endcase
    end
    check_eq("z_lsb_count", 16'(lsb_cnt), 16'd1);
    check_eq("z_ready_count", 16'(rdy_cnt), 16'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
